// File: rtl/floor_request_dispatcher_if.sv
// Call-button / elevator-FSM bundle for floor_request_dispatcher.
// slave = dispatcher side, master = elevator FSM / button front end side.
interface floor_request_dispatcher_if;
  logic [7:0] call_btn;
  logic [3:0] current_floor;
  logic       elevator_idle;
  logic [3:0] target_floor;
  logic [7:0] pending;
  logic       door_open;
  logic       dir_up;

  modport master (
    output call_btn, current_floor, elevator_idle,
    input  target_floor, pending, door_open, dir_up
  );

  modport slave (
    input  call_btn, current_floor, elevator_idle,
    output target_floor, pending, door_open, dir_up
  );
endinterface

// File: rtl/floor_request_dispatcher.sv
// SCAN-order floor request dispatcher with door-hold timing.
// Optional HOME_RETURN_EN: send the car to floor 0 after HOME_TIMEOUT idle cycles.

module floor_req_cell (
  input  logic clk,
  input  logic rst,
  input  logic rise,
  input  logic set_blk,
  input  logic clr,
  output logic pend
);
  logic pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (rise && !set_blk) pend_d = 1'b1;
    if (clr)              pend_d = 1'b0;  // a serve beats a same-cycle press
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  assign pend = pend_q;
endmodule

module floor_request_dispatcher #(
  parameter int unsigned DOOR_CYCLES  = 10000000,
  parameter int unsigned HOME_TIMEOUT = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  floor_request_dispatcher_if.slave bus
);
  localparam int NUM_FLOORS = 8;
  localparam int CW         = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, TRAVEL, DOOR_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              tgt_q, tgt_d;
  logic                    dir_q, dir_d;
  logic                    door_q, door_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0]   btn_q, btn_d;
  logic [NUM_FLOORS-1:0]   rise, pend, set_blk, clr;
  logic                    arrive;
  logic                    lo_ge_v, lo_gt_v, hi_lt_v, hi_le_v;
  logic [3:0]              lo_ge, lo_gt, hi_lt, hi_le;

`ifdef HOME_RETURN_EN
  localparam logic [31:0] HOME_LAST = 32'(HOME_TIMEOUT - 1);
  logic [31:0] idle_cnt_q, idle_cnt_d;
`else
  // HOME_TIMEOUT only matters for the home-return build
  if (HOME_TIMEOUT == 0) begin : g_home_unused
  end
`endif

  assign btn_d  = bus.call_btn;
  assign rise   = bus.call_btn & ~btn_q;
  assign arrive = (state_q == TRAVEL) && bus.elevator_idle &&
                  (bus.current_floor == tgt_q);

  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_blk[i] = (state_q == DOOR_HOLD) && (tgt_q == 4'(i + 1));
      clr[i]     = arrive && (tgt_q == 4'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_cell
    floor_req_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rise    (rise[g]),
      .set_blk (set_blk[g]),
      .clr     (clr[g]),
      .pend    (pend[g])
    );
  end

  // Nearest pending floor on each side of the car; bit i is floor i+1.
  always_comb begin
    lo_ge_v = 1'b0; lo_ge = '0;
    lo_gt_v = 1'b0; lo_gt = '0;
    hi_lt_v = 1'b0; hi_lt = '0;
    hi_le_v = 1'b0; hi_le = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pend[i] && (4'(i + 1) >= bus.current_floor)) begin lo_ge_v = 1'b1; lo_ge = 4'(i + 1); end
      if (pend[i] && (4'(i + 1) >  bus.current_floor)) begin lo_gt_v = 1'b1; lo_gt = 4'(i + 1); end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i] && (4'(i + 1) <  bus.current_floor)) begin hi_lt_v = 1'b1; hi_lt = 4'(i + 1); end
      if (pend[i] && (4'(i + 1) <= bus.current_floor)) begin hi_le_v = 1'b1; hi_le = 4'(i + 1); end
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef HOME_RETURN_EN
    idle_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pend != '0) state_d = SELECT;
`ifdef HOME_RETURN_EN
        else if ((rise == '0) && (tgt_q != '0)) begin
          if (idle_cnt_q == HOME_LAST) begin
            tgt_d = '0;
            dir_d = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
          end
        end
`endif
      end
      SELECT: begin
        state_d = TRAVEL;
        if (dir_q) begin
          if (lo_ge_v)      tgt_d = lo_ge;
          else if (hi_lt_v) begin tgt_d = hi_lt; dir_d = 1'b0; end
          else              state_d = IDLE;
        end else begin
          if (hi_le_v)      tgt_d = hi_le;
          else if (lo_gt_v) begin tgt_d = lo_gt; dir_d = 1'b1; end
          else              state_d = IDLE;
        end
      end
      TRAVEL: begin
        if (arrive) begin
          cnt_d   = DOOR_LOAD;
          state_d = DOOR_HOLD;
        end
      end
      DOOR_HOLD: begin
        if (cnt_q == '0) state_d = (pend != '0) ? SELECT : IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    door_d = (state_d == DOOR_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      dir_q   <= 1'b1;
      door_q  <= 1'b0;
      cnt_q   <= '0;
      btn_q   <= '1;  // a button held through reset must not latch
`ifdef HOME_RETURN_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      door_q  <= door_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
`ifdef HOME_RETURN_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign bus.target_floor = tgt_q;
  assign bus.pending      = pend;
  assign bus.door_open    = door_q;
  assign bus.dir_up       = dir_q;
endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Bench for floor_request_dispatcher: directed scenarios plus randomized calls
// against a request-set / SCAN-rule reference and a 3-cycles-per-floor car model.
module tb_floor_request_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  floor_request_dispatcher_if bus ();

  floor_request_dispatcher #(.DOOR_CYCLES(4), .HOME_TIMEOUT(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // car model: one floor every 3 cycles toward the requested floor
  logic [3:0] car  = 4'd0;
  int         step = 0;
  always @(posedge clk) begin
    if (car != bus.target_floor) begin
      if (step == 2) begin
        car  <= (bus.target_floor > car) ? car + 4'd1 : car - 4'd1;
        step <= 0;
      end else begin
        step <= step + 1;
      end
    end else begin
      step <= 0;
    end
  end
  assign bus.current_floor = car;
  assign bus.elevator_idle = (car == bus.target_floor);

  function automatic logic [4:0] scan_pick(input logic [7:0] p, input logic [3:0] cur, input logic up);
    int best = -1;
    int c = int'(cur);
    if (up) begin
      for (int f = 1; f <= 8; f++) if (p[f-1] && f >= c && best < 0) best = f;
      if (best >= 0) return {1'b1, 4'(best)};
      for (int f = 8; f >= 1; f--) if (p[f-1] && f < c && best < 0) best = f;
      return {1'b0, 4'(best)};
    end else begin
      for (int f = 8; f >= 1; f--) if (p[f-1] && f <= c && best < 0) best = f;
      if (best >= 0) return {1'b0, 4'(best)};
      for (int f = 1; f <= 8; f++) if (p[f-1] && f > c && best < 0) best = f;
      return {1'b1, 4'(best)};
    end
  endfunction

  task automatic wait_door(input logic lvl, input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (bus.door_open === lvl) begin n = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.call_btn = 8'h04;
    repeat (3) @(negedge clk);
    checks++; if (bus.target_floor !== 4'd0) begin failures++; $display("FAIL rst_target got=%0d exp=0", bus.target_floor); end
    checks++; if (bus.pending !== 8'h00) begin failures++; $display("FAIL rst_pending got=%h exp=00", bus.pending); end
    checks++; if (bus.dir_up !== 1'b1) begin failures++; $display("FAIL rst_dir got=%0d exp=1", bus.dir_up); end
    checks++; if (bus.door_open !== 1'b0) begin failures++; $display("FAIL rst_door got=%0d exp=0", bus.door_open); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.pending !== 8'h00) begin failures++; $display("FAIL rst_held_btn got=%h exp=00", bus.pending); end
    bus.call_btn = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.pending !== 8'h00) begin failures++; $display("FAIL rst_release got=%h exp=00", bus.pending); end
  endtask

  task automatic test_single();
    int n;
    bus.call_btn = 8'h04;
    @(negedge clk);
    checks++; if (bus.pending !== 8'h04) begin failures++; $display("FAIL single_latch got=%h exp=04", bus.pending); end
    bus.call_btn = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.target_floor !== 4'd3) begin failures++; $display("FAIL single_target got=%0d exp=3", bus.target_floor); end
    checks++; if (bus.dir_up !== 1'b1) begin failures++; $display("FAIL single_dir got=%0d exp=1", bus.dir_up); end
    wait_door(1'b1, 60, n);
    checks++; if (n < 0) begin failures++; $display("FAIL single_arrive got=timeout exp=door_open"); end
    checks++; if (bus.pending !== 8'h00) begin failures++; $display("FAIL single_clear got=%h exp=00", bus.pending); end
    checks++; if (car !== 4'd3) begin failures++; $display("FAIL single_car got=%0d exp=3", car); end
    wait_door(1'b0, 20, n);
    checks++; if (n != 4) begin failures++; $display("FAIL single_door_len got=%0d exp=4", n); end
  endtask

  task automatic test_scan();
    int n;
    logic [3:0] got [3];
    logic       gdir [3];
    logic [3:0] exp_f [3] = '{4'd5, 4'd7, 4'd2};
    logic       exp_d [3] = '{1'b1, 1'b1, 1'b0};
    bus.call_btn = 8'h52;
    @(negedge clk);
    checks++; if (bus.pending !== 8'h52) begin failures++; $display("FAIL scan_latch got=%h exp=52", bus.pending); end
    bus.call_btn = 8'h00;
    for (int k = 0; k < 3; k++) begin
      wait_door(1'b1, 120, n);
      got[k] = bus.target_floor; gdir[k] = bus.dir_up;
      wait_door(1'b0, 20, n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (got[k] !== exp_f[k]) begin failures++; $display("FAIL scan_order[%0d] got=%0d exp=%0d", k, got[k], exp_f[k]); end
      checks++; if (gdir[k] !== exp_d[k]) begin failures++; $display("FAIL scan_dir[%0d] got=%0d exp=%0d", k, gdir[k], exp_d[k]); end
    end
    checks++; if (bus.pending !== 8'h00) begin failures++; $display("FAIL scan_drained got=%h exp=00", bus.pending); end
  endtask

  task automatic test_same_floor();
    int n;
    bus.call_btn = 8'h08;
    @(negedge clk); bus.call_btn = 8'h00;
    wait_door(1'b1, 80, n);
    checks++; if (bus.target_floor !== 4'd4 || car !== 4'd4) begin failures++; $display("FAIL reach4 got=%0d/%0d exp=4", bus.target_floor, car); end
    wait_door(1'b0, 20, n);
    bus.call_btn = 8'h08;
    @(negedge clk); bus.call_btn = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.target_floor !== 4'd4) begin failures++; $display("FAIL here_target got=%0d exp=4", bus.target_floor); end
    checks++; if (bus.door_open !== 1'b0) begin failures++; $display("FAIL here_door_early got=%0d exp=0", bus.door_open); end
    @(negedge clk);
    checks++; if (bus.door_open !== 1'b1) begin failures++; $display("FAIL here_door got=%0d exp=1", bus.door_open); end
    checks++; if (bus.pending !== 8'h00) begin failures++; $display("FAIL here_clear got=%h exp=00", bus.pending); end
    bus.call_btn = 8'h48;
    @(negedge clk); bus.call_btn = 8'h00;
    checks++; if (bus.pending !== 8'h40) begin failures++; $display("FAIL hold_ignore got=%h exp=40", bus.pending); end
    wait_door(1'b0, 20, n);
    wait_door(1'b1, 80, n);
    checks++; if (bus.target_floor !== 4'd7 || car !== 4'd7) begin failures++; $display("FAIL after_hold got=%0d/%0d exp=7", bus.target_floor, car); end
    checks++; if (bus.dir_up !== 1'b1) begin failures++; $display("FAIL after_hold_dir got=%0d exp=1", bus.dir_up); end
  endtask

  task automatic test_home();
    int n;
    int k;
    wait_door(1'b0, 20, n);
    bus.call_btn = 8'h10;
    @(negedge clk); bus.call_btn = 8'h00;
    wait_door(1'b1, 80, n);
    checks++; if (bus.target_floor !== 4'd5) begin failures++; $display("FAIL home_serve5 got=%0d exp=5", bus.target_floor); end
    wait_door(1'b0, 20, n);
`ifdef HOME_RETURN_EN
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.target_floor == 4'd0) break;
    end
    checks++; if (k != 20) begin failures++; $display("FAIL home_delay got=%0d exp=20", k); end
    checks++; if (bus.dir_up !== 1'b0) begin failures++; $display("FAIL home_dir got=%0d exp=0", bus.dir_up); end
`else
    k = 0;
    repeat (60) @(negedge clk);
    checks++; if (bus.target_floor !== 4'd5) begin failures++; $display("FAIL no_home got=%0d exp=5", bus.target_floor); end
    checks++; if (car !== 4'd5) begin failures++; $display("FAIL no_home_car got=%0d exp=5", car); end
`endif
  endtask

  task automatic test_reset_mid();
    bus.call_btn = 8'h80;
    @(negedge clk); bus.call_btn = 8'h00;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.target_floor !== 4'd0 || bus.pending !== 8'h00) begin failures++; $display("FAIL mid_rst got=%0d/%h exp=0/00", bus.target_floor, bus.pending); end
    checks++; if (bus.dir_up !== 1'b1 || bus.door_open !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%0d/%0d exp=1/0", bus.dir_up, bus.door_open); end
    rst = 1'b0;
    for (int k = 0; k < 80 && car != 4'd0; k++) @(negedge clk);
    checks++; if (car !== 4'd0) begin failures++; $display("FAIL mid_rst_home got=%0d exp=0", car); end
  endtask

  task automatic test_random();
    logic [7:0] drv, drv1, drv2, r, mpend, mpend_prev;
    logic [3:0] last_pick, exp_f;
    logic [4:0] pk;
    logic       mdir, exp_d, prev_door, tb_idle, idle_wait, check_due, snap, done;
    int         door_len, idle_len;
    rst = 1'b1; bus.call_btn = 8'h00;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 80 && car != 4'd0; k++) @(negedge clk);
    @(negedge clk);
    drv1 = '0; drv2 = '0; mpend = '0; mpend_prev = '0; last_pick = '0; exp_f = '0; exp_d = 1'b1;
    mdir = 1'b1; prev_door = 1'b0; tb_idle = 1'b1; idle_wait = 1'b0; check_due = 1'b0; done = 1'b0;
    door_len = 0; idle_len = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      drv = 8'h00;
      if (cyc < 1500) begin
        case ($urandom_range(0, 9))
          0:       drv = drv1;
          1, 2:    drv = 8'h01 << $urandom_range(0, 7);
          default: drv = 8'h00;
        endcase
        if (tb_idle && idle_len >= 8) drv = drv | ~drv1;
      end
      bus.call_btn = drv; drv2 = drv1; drv1 = drv;
      @(negedge clk);
      snap = 1'b0;
      r = drv1 & ~drv2;
      for (int i = 0; i < 8; i++)
        if (r[i] && !(prev_door && last_pick == 4'(i + 1))) mpend[i] = 1'b1;
      if (bus.door_open && !prev_door) begin
        checks++; if (tb_idle || car !== last_pick) begin failures++; $display("FAIL rnd_arrive got=%0d exp=%0d", car, last_pick); end
        mpend[last_pick - 4'd1] = 1'b0;
        door_len = 0;
      end
      if (bus.door_open) door_len++;
      checks++; if (bus.pending !== mpend) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", cyc, bus.pending, mpend); end
      if (check_due) begin
        checks++; if (bus.target_floor !== exp_f) begin failures++; $display("FAIL rnd_target cyc=%0d got=%0d exp=%0d", cyc, bus.target_floor, exp_f); end
        checks++; if (bus.dir_up !== exp_d) begin failures++; $display("FAIL rnd_dir cyc=%0d got=%0d exp=%0d", cyc, bus.dir_up, exp_d); end
        last_pick = exp_f; mdir = exp_d; check_due = 1'b0;
      end
      if (!bus.door_open && prev_door) begin
        checks++; if (door_len != 4) begin failures++; $display("FAIL rnd_door_len got=%0d exp=4", door_len); end
        if (mpend_prev != 8'h00) snap = 1'b1;
        else                     tb_idle = 1'b1;
      end
      if (idle_wait) begin snap = 1'b1; idle_wait = 1'b0; end
      if (tb_idle && mpend != 8'h00) begin idle_wait = 1'b1; tb_idle = 1'b0; end
      if (snap) begin
        pk = scan_pick(mpend, car, mdir);
        exp_f = pk[3:0]; exp_d = pk[4]; check_due = 1'b1;
      end
      idle_len   = tb_idle ? idle_len + 1 : 0;
      prev_door  = bus.door_open;
      mpend_prev = mpend;
      if (cyc >= 1500 && tb_idle && mpend == 8'h00 && !bus.door_open && !idle_wait && !check_due) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("FAIL rnd_drain got=busy exp=idle pending=%h", mpend); end
  endtask

  initial begin
    bus.call_btn = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_scan();
    test_same_floor();
    test_home();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
